// File: rtl/write_port_arbiter_pkg.sv
// Shared encodings for the write-port arbiter: FSM state codes and AXI response codes.
// Also supplies default AXI widths for builds that do not define MEM_ADDR_WIDTH / MEM_DATA_WIDTH.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 64
`endif

package write_port_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_ADDR = 2'd1;
    localparam arb_state_t ST_DATA = 2'd2;
    localparam arb_state_t ST_RESP = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/write_port_arbiter_rr_select.sv
// rr_select: combinational pick of the first requester after last_grant, wrapping modulo NUM_REQ.
// Zero latency; winner_vld is low when no request bit is set.
module rr_select #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [1:0]         winner,
    output logic               winner_vld
);

    int cand;

    always_comb begin
        winner     = 2'd0;
        winner_vld = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!winner_vld && (cand == i) && req[i]) begin
                    winner     = 2'(i);
                    winner_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// write_port_arbiter: funnels NUM_REQ AXI4 write requesters onto one master, one whole burst (AW->W->B) at a time.
// 1-cycle arbitration in IDLE, then all channels pass through combinationally so backpressure follows the slave.
// Define WRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
import write_port_arbiter_pkg::*;

module write_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH
) (
    input  logic                                system_clk,
    input  logic                                rst,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [NUM_REQ*8-1:0]                s_axi_awlen,
    input  logic [NUM_REQ-1:0]                  s_axi_awvalid,
    output logic [NUM_REQ-1:0]                  s_axi_awready,
    input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [NUM_REQ-1:0]                  s_axi_wlast,
    input  logic [NUM_REQ-1:0]                  s_axi_wvalid,
    output logic [NUM_REQ-1:0]                  s_axi_wready,
    output logic [NUM_REQ*2-1:0]                s_axi_bresp,
    output logic [NUM_REQ-1:0]                  s_axi_bvalid,
    input  logic [NUM_REQ-1:0]                  s_axi_bready,
    output logic [MEM_ADDR_WIDTH-1:0]           m00_axi_awaddr,
    output logic [7:0]                          m00_axi_awlen,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [MEM_DATA_WIDTH-1:0]           m00_axi_wdata,
    output logic                                m00_axi_wlast,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [1:0]                          grant_id,
    output logic                                arb_busy
);

    arb_state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] sel_last;
    logic [1:0] sel_idx;
    logic       sel_vld;
    logic       aw_hs, w_last_hs, b_hs;

`ifdef WRITE_ARB_FIXED_PRIO_EN
    // Starting the search just past the top index makes it begin at 0 every time: plain fixed priority.
    assign sel_last = 2'(NUM_REQ - 1);
`else
    logic [1:0] last_grant_q, last_grant_d;
    assign sel_last = last_grant_q;
`endif

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req        (s_axi_awvalid),
        .last_grant (sel_last),
        .winner     (sel_idx),
        .winner_vld (sel_vld)
    );

    always_comb begin : channel_mux
        m00_axi_awaddr  = '0;
        m00_axi_awlen   = '0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wdata   = '0;
        m00_axi_wlast   = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        s_axi_awready   = '0;
        s_axi_wready    = '0;
        s_axi_bvalid    = '0;
        s_axi_bresp     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                m00_axi_awaddr  = s_axi_awaddr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                m00_axi_awlen   = s_axi_awlen[i*8 +: 8];
                m00_axi_wdata   = s_axi_wdata[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
                m00_axi_wlast   = s_axi_wlast[i];
                s_axi_bresp[i*2 +: 2] = m00_axi_bresp;
                // Valids and readies only open in the phase that owns them; everyone else sees 0.
                if (state_q == ST_ADDR) begin
                    m00_axi_awvalid  = s_axi_awvalid[i];
                    s_axi_awready[i] = m00_axi_awready;
                end
                if (state_q == ST_DATA) begin
                    m00_axi_wvalid   = s_axi_wvalid[i];
                    s_axi_wready[i]  = m00_axi_wready;
                end
                if (state_q == ST_RESP) begin
                    s_axi_bvalid[i]  = m00_axi_bvalid;
                    m00_axi_bready   = s_axi_bready[i];
                end
            end
        end
    end

    assign aw_hs     = m00_axi_awvalid && m00_axi_awready;
    assign w_last_hs = m00_axi_wvalid && m00_axi_wready && m00_axi_wlast;
    assign b_hs      = (state_q == ST_RESP) && m00_axi_bvalid && m00_axi_bready;

    always_comb begin : fsm_next
        state_d = state_q;
        grant_d = grant_q;
`ifndef WRITE_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_d = sel_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: if (aw_hs)     state_d = ST_DATA;
            ST_DATA: if (w_last_hs) state_d = ST_RESP;
            ST_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
`ifndef WRITE_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
`ifndef WRITE_ARB_FIXED_PRIO_EN
            last_grant_q <= 2'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifndef WRITE_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign grant_id = grant_q;
    assign arb_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed plus randomized bench for write_port_arbiter; the grant order comes from a small arbitration
// model and all beat data comes from values the bench itself generated.
module tb_write_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                 system_clk = 1'b0;
    logic                 rst;
    logic [NR*AW-1:0]     s_axi_awaddr;
    logic [NR*8-1:0]      s_axi_awlen;
    logic [NR-1:0]        s_axi_awvalid;
    logic [NR-1:0]        s_axi_awready;
    logic [NR*DW-1:0]     s_axi_wdata;
    logic [NR-1:0]        s_axi_wlast;
    logic [NR-1:0]        s_axi_wvalid;
    logic [NR-1:0]        s_axi_wready;
    logic [NR*2-1:0]      s_axi_bresp;
    logic [NR-1:0]        s_axi_bvalid;
    logic [NR-1:0]        s_axi_bready;
    logic [AW-1:0]        m00_axi_awaddr;
    logic [7:0]           m00_axi_awlen;
    logic                 m00_axi_awvalid;
    logic                 m00_axi_awready;
    logic [DW-1:0]        m00_axi_wdata;
    logic                 m00_axi_wlast;
    logic                 m00_axi_wvalid;
    logic                 m00_axi_wready;
    logic [1:0]           m00_axi_bresp;
    logic                 m00_axi_bvalid;
    logic                 m00_axi_bready;
    logic [1:0]           grant_id;
    logic                 arb_busy;

    int errors = 0;
    int checks = 0;
    int last_grant_m;
    int w_hs_cnt = 0;
    int grant_log[$];

    write_port_arbiter #(.NUM_REQ(NR), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
        .system_clk(system_clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen),
        .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m00_axi_awready),
        .m00_axi_wdata(m00_axi_wdata), .m00_axi_wlast(m00_axi_wlast),
        .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
        .m00_axi_bready(m00_axi_bready),
        .grant_id(grant_id), .arb_busy(arb_busy)
    );

    always #5 system_clk = ~system_clk;

    always @(posedge system_clk) begin
        if (!rst && m00_axi_wvalid && m00_axi_wready) w_hs_cnt <= w_hs_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    // Arbitration rule from the requirement text, independent of how the RTL searches.
    function automatic int model_pick(input logic [NR-1:0] req, input int last);
        int c;
`ifdef WRITE_ARB_FIXED_PRIO_EN
        c = last;
        for (int i = 0; i < NR; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (req[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_wlast = '0; s_axi_bready = '0;
        m00_axi_wready = 1'b0; m00_axi_bvalid = 1'b0; m00_axi_bresp = 2'b00;
        tick(); tick();
        rst = 1'b0;
        last_grant_m = NR - 1;
    endtask

    task automatic set_req(input int i, input int beats);
        s_axi_awaddr[i*AW +: AW] = $urandom;
        s_axi_awlen[i*8 +: 8]    = 8'(beats - 1);
    endtask

    // One complete burst; awvalid must already be set for the competing requesters, FSM in IDLE.
    task automatic do_burst(input int beats, input logic [1:0] bresp_v, input bit toggle, input bit keep);
        int exp_g, cyc, beat, hs0;
        logic [63:0] e;
        logic [DW-1:0] d;
        exp_g = model_pick(s_axi_awvalid, last_grant_m);
        cyc = 0;
        do begin
            tick(); #1; cyc++;
        end while (s_axi_awready == '0 && cyc < 20);
        check("arb_latency", 64'(cyc), 64'd1);
        check("grant_id", 64'(grant_id), 64'(exp_g));
        check("awready_onehot", 64'(s_axi_awready), 64'd1 << exp_g);
        check("m_awaddr", 64'(m00_axi_awaddr), 64'(s_axi_awaddr[exp_g*AW +: AW]));
        check("m_awlen", 64'(m00_axi_awlen), 64'(beats - 1));
        check("busy_addr", 64'(arb_busy), 64'd1);
        grant_log.push_back(int'(grant_id));
        tick();
        s_axi_awvalid[exp_g] = keep;
        hs0 = w_hs_cnt; beat = 0; cyc = 0;
        while (beat < beats && cyc < 400) begin
            for (int i = 0; i < NR; i++) begin
                s_axi_wvalid[i] = 1'b1;
                s_axi_wdata[i*DW +: DW] = $urandom;
                s_axi_wlast[i] = (i == exp_g) ? (beat == beats - 1) : 1'b1;
            end
            d = s_axi_wdata[exp_g*DW +: DW];
            m00_axi_wready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            e = m00_axi_wready ? (64'd1 << exp_g) : 64'd0;
            check("s_wready_track", 64'(s_axi_wready), e);
            if (m00_axi_wvalid && m00_axi_wready) begin
                check("m_wdata", 64'(m00_axi_wdata), 64'(d));
                check("m_wlast", 64'(m00_axi_wlast), 64'(beat == beats - 1));
                beat++;
            end
            tick(); cyc++;
        end
        check("w_beats", 64'(beat), 64'(beats));
        check("w_hs_count", 64'(w_hs_cnt - hs0), 64'(beats));
        s_axi_wvalid = '0; s_axi_wlast = '0; m00_axi_wready = 1'b0;
        m00_axi_bvalid = 1'b1; m00_axi_bresp = bresp_v; s_axi_bready = '1;
        #1;
        check("bvalid_route", 64'(s_axi_bvalid), 64'd1 << exp_g);
        check("bresp_pass", 64'(s_axi_bresp[exp_g*2 +: 2]), 64'(bresp_v));
        check("m_bready", 64'(m00_axi_bready), 64'd1);
        tick();
        m00_axi_bvalid = 1'b0; s_axi_bready = '0;
        #1;
        check("idle_after_b", 64'(arb_busy), 64'd0);
        last_grant_m = exp_g;
    endtask

    initial begin
        int mask, nb, cyc;
        int exp_seq[4];
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_wdata = '0;
        m00_axi_awready = 1'b1;
        reset_dut();
        rst = 1'b1;
        tick(); #1;
        check("rst_busy", 64'(arb_busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        check("rst_wready", 64'(s_axi_wready), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_m_valids", {61'd0, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready}, 64'd0);
        rst = 1'b0;
        tick();

        // s0 alone, 64-beat burst
        set_req(0, 64);
        s_axi_awvalid = 2'b01;
        do_burst(64, 2'b00, 1'b0, 1'b0);

        // s0 and s1 both requesting continuously
        reset_dut();
        grant_log.delete();
        set_req(0, 4); set_req(1, 4);
        s_axi_awvalid = 2'b11;
        for (int n = 0; n < 4; n++) do_burst(4, 2'b00, 1'b0, 1'b1);
`ifdef WRITE_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        for (int n = 0; n < 4; n++) check("grant_order", 64'(grant_log[n]), 64'(exp_seq[n]));
        s_axi_awvalid = '0;

        // wready toggling during a 4-beat burst
        set_req(1, 4);
        s_axi_awvalid = 2'b10;
        do_burst(4, 2'b00, 1'b1, 1'b0);

        // slave error response
        set_req(0, 2);
        s_axi_awvalid = 2'b01;
        do_burst(2, 2'b10, 1'b0, 1'b0);

        // awvalid withdrawn before the arbitration edge is ignored
        s_axi_awvalid = 2'b10;
        #2;
        s_axi_awvalid = 2'b00;
        tick(); #1;
        check("withdrawn_req", 64'(arb_busy), 64'd0);

        // randomized bursts
        for (int n = 0; n < 8; n++) begin
            mask = $urandom_range(1, 3);
            nb = $urandom_range(1, 8);
            for (int i = 0; i < NR; i++) set_req(i, nb);
            s_axi_awvalid = 2'(mask);
            do_burst(nb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            s_axi_awvalid = '0;
        end

        // reset while in DATA
        set_req(1, 8);
        s_axi_awvalid = 2'b10;
        cyc = 0;
        do begin
            tick(); #1; cyc++;
        end while (s_axi_awready == '0 && cyc < 20);
        check("rst_test_grant", 64'(grant_id), 64'd1);
        tick();
        s_axi_awvalid = '0;
        s_axi_wvalid = 2'b11; m00_axi_wready = 1'b1;
        tick(); tick();
        #1;
        check("mid_data_busy", 64'(arb_busy), 64'd1);
        rst = 1'b1;
        tick(); #1;
        check("rst_mid_busy", 64'(arb_busy), 64'd0);
        check("rst_mid_wvalid", 64'(m00_axi_wvalid), 64'd0);
        check("rst_mid_grant", 64'(grant_id), 64'd0);
        check("rst_mid_wready", 64'(s_axi_wready), 64'd0);
        rst = 1'b0;
        s_axi_wvalid = '0; m00_axi_wready = 1'b0;
        last_grant_m = NR - 1;

        // recovery after the abandoned burst
        set_req(1, 3);
        s_axi_awvalid = 2'b10;
        do_burst(3, 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_port_arbiter.md
WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of AXI4 write requesters (2..4).
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default `MEM_ADDR_WIDTH, AXI address width.
REQ-003 SHALL have parameter MEM_DATA_WIDTH, default `MEM_DATA_WIDTH, AXI data width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports `system_clk  in  1  clock` and `rst  in  1  synchronous reset, active-high`.
REQ-005 SHALL have port `s_axi_awaddr  in  NUM_REQ*MEM_ADDR_WIDTH  per-requester burst address; requester i at slice i`.
REQ-006 SHALL have port `s_axi_awlen  in  NUM_REQ*8  per-requester burst length-1`.
REQ-007 SHALL have ports `s_axi_awvalid  in  NUM_REQ` and `s_axi_awready  out  NUM_REQ`, per-requester AW handshake.
REQ-008 SHALL have ports `s_axi_wdata  in  NUM_REQ*MEM_DATA_WIDTH`, `s_axi_wlast  in  NUM_REQ` and `s_axi_wvalid  in  NUM_REQ`, per-requester W channel.
REQ-009 SHALL have port `s_axi_wready  out  NUM_REQ  per-requester W ready`.
REQ-010 SHALL have ports `s_axi_bresp  out  NUM_REQ*2`, `s_axi_bvalid  out  NUM_REQ` and `s_axi_bready  in  NUM_REQ`, per-requester B channel.
REQ-011 SHALL have master ports `m00_axi_awaddr  out  MEM_ADDR_WIDTH`, `m00_axi_awlen  out  8`, `m00_axi_awvalid  out  1` and `m00_axi_awready  in  1`.
REQ-012 SHALL have master ports `m00_axi_wdata  out  MEM_DATA_WIDTH`, `m00_axi_wlast  out  1`, `m00_axi_wvalid  out  1` and `m00_axi_wready  in  1`.
REQ-013 SHALL have master ports `m00_axi_bresp  in  2`, `m00_axi_bvalid  in  1` and `m00_axi_bready  out  1`.
REQ-014 SHALL have ports `grant_id  out  2  index of owning requester` and `arb_busy  out  1  a burst is in flight`.

Function
REQ-015 SHALL run an FSM with states IDLE, ADDR, DATA, RESP.
REQ-016 IDLE: with any s_axi_awvalid set, SHALL register the winner into grant_id and go to ADDR on the next cycle (1-cycle arbitration latency).
REQ-017 ADDR: m00_axi_aw* SHALL mirror the granted requester (awvalid/awaddr/awlen), and s_axi_awready[grant] = m00_axi_awready; on the handshake the FSM SHALL go to DATA.
REQ-018 DATA: W signals SHALL mux combinationally from grant, and s_axi_wready[grant] = m00_axi_wready; on a handshake with wlast=1 the FSM SHALL go to RESP.
REQ-019 RESP: s_axi_bvalid[grant] = m00_axi_bvalid, bresp SHALL pass through, m00_axi_bready = s_axi_bready[grant]; on the handshake the FSM SHALL go to IDLE.
REQ-020 Non-granted requesters SHALL see awready, wready and bvalid at 0 at all times; grant SHALL be held from ADDR through the B handshake (no interleaving).
REQ-021 Default arbitration SHALL be round-robin: the search starts at last_grant+1 modulo NUM_REQ, and last_grant updates on the B handshake.
REQ-022 A single requestor SHALL be granted back-to-back with no extra cycles beyond IDLE; an awvalid deasserted before grant SHALL be ignored.
REQ-023 The awlen value SHALL NOT be checked; burst end is defined solely by wlast.
REQ-024 arb_busy SHALL be 1 in ADDR, DATA and RESP.
REQ-025 A mid-operation reset SHALL abandon the burst; the block performs no AXI recovery.

Reset
REQ-026 On rst: FSM SHALL be in IDLE; grant_id and arb_busy SHALL be 0; last_grant SHALL be NUM_REQ-1 (so requester 0 is favoured first); all valid/ready outputs SHALL be 0.

Configuration
REQ-027 With WRITE_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and last_grant SHALL be unused; without it, arbitration SHALL be round-robin per REQ-021.

Structure
REQ-028 The FSM state encoding (2-bit IDLE/ADDR/DATA/RESP) and the AXI response codes SHALL live in the shared accelerator package/parameters file.
REQ-029 Requester selection SHALL be a sub-module rr_select (request vector + last_grant -> winner index, valid), combinational.

Verification
REQ-030 Bench SHALL cover: s0 alone, awlen=63, 64 beats, wready always 1 -> grant_id=0; 64 W beats forwarded, wlast on beat 64; bvalid routed only to s0.
REQ-031 Bench SHALL cover: s0 and s1 requesting continuously, 4 bursts -> grant order 0,1,0,1; no W beat from the non-granted requester.
REQ-032 Bench SHALL cover: as REQ-031 with WRITE_ARB_FIXED_PRIO_EN -> grant order 0,0,0,0 while s0 holds awvalid.
REQ-033 Bench SHALL cover: m00_axi_wready toggling 1,0,1,0 during a 4-beat burst -> exactly 4 handshakes, and s_axi_wready tracks m00_axi_wready.
REQ-034 Bench SHALL cover: bresp=2'b10 from the slave -> s_axi_bresp for the granted requester = 2'b10; FSM returns to IDLE.
REQ-035 Bench SHALL cover: rst asserted during DATA -> next cycle FSM in IDLE, m00_axi_wvalid=0 and arb_busy=0.
